// File: rtl/cv32e40s_clic_arbiter.sv
// ============================================================================
// cv32e40s_clic_arbiter - CLIC source collection, pending state and
// level/id tree arbitration feeding the core's registered CLIC request.
// Optional: CV32E40S_CLIC_ARB_SYNC_EN adds a 2-flop input synchronizer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cv32e40s_clic_arbiter #(
    parameter int NUM_SRC         = 32,
    parameter int SMCLIC_ID_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC-1:0]         src_i,
    input  logic                       cfg_we_i,
    input  logic [SMCLIC_ID_WIDTH-1:0] cfg_idx_i,
    input  logic [10:0]                cfg_wdata_i,
    input  logic                       irq_ack_i,
    input  logic [SMCLIC_ID_WIDTH-1:0] irq_ack_id_i,
    output logic                       clic_irq_o,
    output logic [SMCLIC_ID_WIDTH-1:0] clic_irq_id_o,
    output logic [7:0]                 clic_irq_level_o,
    output logic [1:0]                 clic_irq_priv_o,
    output logic                       clic_irq_shv_o,
    output logic [NUM_SRC-1:0]         ip_o
);

    localparam int DEPTH  = $clog2(NUM_SRC);
    localparam int LEAVES = 1 << DEPTH;

    logic [NUM_SRC-1:0] src_s;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] ip;
    logic [NUM_SRC-1:0] ie;
    logic [NUM_SRC-1:0] trig_edge;
    logic [NUM_SRC-1:0] shv;
    logic [7:0]         level [NUM_SRC];

`ifdef CV32E40S_CLIC_ARB_SYNC_EN
    logic [NUM_SRC-1:0] sync_ff1;
    logic [NUM_SRC-1:0] sync_ff2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff1 <= '0;
            sync_ff2 <= '0;
        end else begin
            sync_ff1 <= src_i;
            sync_ff2 <= sync_ff1;
        end
    end

    assign src_s = sync_ff2;
`else
    assign src_s = src_i;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q <= '0;
        end else begin
            src_q <= src_s;
        end
    end

    // Per-source configuration and pending state
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic       cfg_hit;
        logic       ack_hit;
        logic       ip_r;
        logic       ie_r;
        logic       edge_r;
        logic       shv_r;
        logic [7:0] lvl_r;

        assign cfg_hit = cfg_we_i && (cfg_idx_i == SMCLIC_ID_WIDTH'(i));
        assign ack_hit = irq_ack_i && (irq_ack_id_i == SMCLIC_ID_WIDTH'(i));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ip_r   <= 1'b0;
                ie_r   <= 1'b0;
                edge_r <= 1'b0;
                shv_r  <= 1'b0;
                lvl_r  <= 8'd0;
            end else begin
                if (cfg_hit) begin
                    ie_r   <= cfg_wdata_i[10];
                    edge_r <= cfg_wdata_i[9];
                    shv_r  <= cfg_wdata_i[8];
                    lvl_r  <= cfg_wdata_i[7:0];
                end
                // A trigger-mode change discards stale pending state outright
                if (cfg_hit && (cfg_wdata_i[9] != edge_r)) begin
                    ip_r <= 1'b0;
                end else if (edge_r) begin
                    if (src_s[i] && !src_q[i]) begin
                        ip_r <= 1'b1;
                    end else if (ack_hit) begin
                        ip_r <= 1'b0;
                    end
                end else begin
                    ip_r <= src_s[i];
                end
            end
        end

        assign ip[i]        = ip_r;
        assign ie[i]        = ie_r;
        assign trig_edge[i] = edge_r;
        assign shv[i]       = shv_r;
        assign level[i]     = lvl_r;
    end

    // Balanced comparator tree; a zero level marks "no candidate" at every node
    for (genvar l = 0; l <= DEPTH; l++) begin : g_lvl
        localparam int N = LEAVES >> l;
        logic [7:0]                 lvl [N];
        logic [SMCLIC_ID_WIDTH-1:0] id  [N];
        logic [N-1:0]               sh;

        if (l == 0) begin : g_leaf
            for (genvar j = 0; j < N; j++) begin : g_j
                if (j < NUM_SRC) begin : g_real
                    assign lvl[j] = (ip[j] && ie[j]) ? level[j] : 8'd0;
                    assign id[j]  = SMCLIC_ID_WIDTH'(j);
                    assign sh[j]  = shv[j];
                end else begin : g_pad
                    assign lvl[j] = 8'd0;
                    assign id[j]  = SMCLIC_ID_WIDTH'(j);
                    assign sh[j]  = 1'b0;
                end
            end
        end else begin : g_node
            for (genvar j = 0; j < N; j++) begin : g_j
                logic take_hi;
                // Upper child holds the higher indices, so >= resolves ties upward
                assign take_hi = g_lvl[l-1].lvl[2*j+1] >= g_lvl[l-1].lvl[2*j];
                assign lvl[j]  = take_hi ? g_lvl[l-1].lvl[2*j+1] : g_lvl[l-1].lvl[2*j];
                assign id[j]   = take_hi ? g_lvl[l-1].id[2*j+1]  : g_lvl[l-1].id[2*j];
                assign sh[j]   = take_hi ? g_lvl[l-1].sh[2*j+1]  : g_lvl[l-1].sh[2*j];
            end
        end
    end

    logic [7:0]                 win_lvl;
    logic [SMCLIC_ID_WIDTH-1:0] win_id;
    logic                       win_shv;

    assign win_lvl = g_lvl[DEPTH].lvl[0];
    assign win_id  = g_lvl[DEPTH].id[0];
    assign win_shv = g_lvl[DEPTH].sh[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clic_irq_o       <= 1'b0;
            clic_irq_id_o    <= '0;
            clic_irq_level_o <= 8'd0;
            clic_irq_shv_o   <= 1'b0;
        end else begin
            clic_irq_o <= (win_lvl != 8'd0);
            if (win_lvl != 8'd0) begin
                clic_irq_id_o    <= win_id;
                clic_irq_level_o <= win_lvl;
                clic_irq_shv_o   <= win_shv;
            end
        end
    end

    assign clic_irq_priv_o = 2'b11;
    assign ip_o            = ip;

endmodule

`default_nettype wire

// File: tb/tb_cv32e40s_clic_arbiter.sv
// ============================================================================
// tb_cv32e40s_clic_arbiter - self-checking bench for cv32e40s_clic_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cv32e40s_clic_arbiter;

`ifdef CV32E40S_CLIC_ARB_SYNC_EN
    localparam int SX = 2;
`else
    localparam int SX = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] src = '0;
    logic        cfg_we = 1'b0;
    logic [4:0]  cfg_idx = '0;
    logic [10:0] cfg_wdata = '0;
    logic        ack = 1'b0;
    logic [4:0]  ack_id = '0;
    logic        irq;
    logic [4:0]  irq_id;
    logic [7:0]  irq_lvl;
    logic [1:0]  irq_priv;
    logic        irq_shv;
    logic [31:0] ip;

    cv32e40s_clic_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .src_i            (src),
        .cfg_we_i         (cfg_we),
        .cfg_idx_i        (cfg_idx),
        .cfg_wdata_i      (cfg_wdata),
        .irq_ack_i        (ack),
        .irq_ack_id_i     (ack_id),
        .clic_irq_o       (irq),
        .clic_irq_id_o    (irq_id),
        .clic_irq_level_o (irq_lvl),
        .clic_irq_priv_o  (irq_priv),
        .clic_irq_shv_o   (irq_shv),
        .ip_o             (ip)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       irq;
        logic [4:0] id;
        logic [7:0] lvl;
        logic       shv;
    } out_t;

    typedef struct packed {
        logic [4:0] ack_id;
        out_t       exp;
    } vec_t;

    out_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic e_irq, input logic [4:0] e_id, input logic [7:0] e_lvl,
                        input logic e_shv);
        out_t e;
        e.irq = e_irq;
        e.id  = e_id;
        e.lvl = e_lvl;
        e.shv = e_shv;
        sb_q.push_back(e);
    endtask

    task automatic check_out(input string name);
        out_t act;
        out_t exp;
        act.irq = irq;
        act.id  = irq_id;
        act.lvl = irq_lvl;
        act.shv = irq_shv;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: no expected entry queued", name);
        end else begin
            exp = sb_q.pop_front();
            if (act !== exp || irq_priv !== 2'b11) begin
                n_fail++;
                $display("FAIL %s: actual irq=%0b id=%0d lvl=%h shv=%0b priv=%b, required irq=%0b id=%0d lvl=%h shv=%0b priv=11",
                         name, act.irq, act.id, act.lvl, act.shv, irq_priv,
                         exp.irq, exp.id, exp.lvl, exp.shv);
            end
        end
    endtask

    task automatic check_ip(input string name, input int idx, input logic e);
        n_checks++;
        if (ip[idx] !== e) begin
            n_fail++;
            $display("FAIL %s: actual ip[%0d]=%b, required %b", name, idx, ip[idx], e);
        end
    endtask

    task automatic check_ipvec(input string name, input logic [31:0] e);
        n_checks++;
        if (ip !== e) begin
            n_fail++;
            $display("FAIL %s: actual ip=%h, required %h", name, ip, e);
        end
    endtask

    task automatic cfg(input int idx, input logic e_ie, input logic e_edge, input logic e_shv,
                       input logic [7:0] lvl);
        cfg_we    = 1'b1;
        cfg_idx   = idx[4:0];
        cfg_wdata = {e_ie, e_edge, e_shv, lvl};
        tick(1);
        cfg_we    = 1'b0;
    endtask

    task automatic do_ack(input logic [4:0] id);
        ack    = 1'b1;
        ack_id = id;
        tick(1);
        ack    = 1'b0;
    endtask

    vec_t tbl [5];

    initial begin
        tbl = '{
            '{5'd9,  '{1'b1, 5'd5,  8'h80, 1'b0}},
            '{5'd5,  '{1'b1, 5'd20, 8'h10, 1'b0}},
            '{5'd3,  '{1'b1, 5'd20, 8'h10, 1'b0}},
            '{5'd20, '{1'b0, 5'd20, 8'h10, 1'b0}},
            '{5'd7,  '{1'b0, 5'd20, 8'h10, 1'b0}}
        };

        // Reset state
        tick(2);
        push(1'b0, 5'd0, 8'h00, 1'b0);
        check_out("reset_state");
        check_ipvec("reset_ip", 32'h0);
        rst = 1'b0;
        tick(1);

        // Single edge source
        cfg(3, 1'b1, 1'b1, 1'b1, 8'h40);
        src[3] = 1'b1;
        tick(1);
        src[3] = 1'b0;
        tick(SX);
        push(1'b0, 5'd0, 8'h00, 1'b0);
        check_out("edge_latency_pre");
        tick(1);
        push(1'b1, 5'd3, 8'h40, 1'b1);
        check_out("edge_fire");
        do_ack(5'd3);
        push(1'b1, 5'd3, 8'h40, 1'b1);
        check_out("ack_same_edge");
        tick(1);
        push(1'b0, 5'd3, 8'h40, 1'b1);
        check_out("ack_clear_hold");

        // Priority and tie-break
        cfg(5, 1'b1, 1'b1, 1'b0, 8'h80);
        cfg(9, 1'b1, 1'b1, 1'b1, 8'h80);
        cfg(20, 1'b1, 1'b1, 1'b0, 8'h10);
        src[5] = 1'b1; src[9] = 1'b1; src[20] = 1'b1;
        tick(1);
        src[5] = 1'b0; src[9] = 1'b0; src[20] = 1'b0;
        tick(SX + 1);
        push(1'b1, 5'd9, 8'h80, 1'b1);
        check_out("tie_high_idx");
        for (int i = 0; i < 5; i++) begin
            push(tbl[i].exp.irq, tbl[i].exp.id, tbl[i].exp.lvl, tbl[i].exp.shv);
            do_ack(tbl[i].ack_id);
            tick(1);
            check_out($sformatf("prio_vec%0d", i));
        end

        // Level-triggered source ignores acks
        cfg(7, 1'b1, 1'b0, 1'b0, 8'h20);
        src[7] = 1'b1;
        tick(SX + 2);
        push(1'b1, 5'd7, 8'h20, 1'b0);
        check_out("lvl_fire");
        do_ack(5'd7);
        tick(1);
        push(1'b1, 5'd7, 8'h20, 1'b0);
        check_out("lvl_ack_ignored");
        src[7] = 1'b0;
        tick(SX + 1);
        push(1'b1, 5'd7, 8'h20, 1'b0);
        check_out("lvl_drop_pre");
        tick(1);
        push(1'b0, 5'd7, 8'h20, 1'b0);
        check_out("lvl_drop");

        // Level 0 and ie=0 sources stay pending but never request
        cfg(11, 1'b1, 1'b1, 1'b0, 8'h00);
        cfg(12, 1'b0, 1'b1, 1'b0, 8'h50);
        src[11] = 1'b1; src[12] = 1'b1;
        tick(1);
        src[11] = 1'b0; src[12] = 1'b0;
        tick(SX + 2);
        check_ip("lvl0_pending", 11, 1'b1);
        check_ip("ie0_pending", 12, 1'b1);
        push(1'b0, 5'd7, 8'h20, 1'b0);
        check_out("masked_no_irq");
        cfg(12, 1'b1, 1'b1, 1'b0, 8'h50);
        tick(1);
        push(1'b1, 5'd12, 8'h50, 1'b0);
        check_out("ie_enable");
        cfg(12, 1'b0, 1'b1, 1'b0, 8'h50);
        tick(1);
        push(1'b0, 5'd12, 8'h50, 1'b0);
        check_out("ie_disable");
        check_ip("ie_disable_keeps_ip", 12, 1'b1);
        cfg(11, 1'b0, 1'b0, 1'b0, 8'h00);
        cfg(12, 1'b0, 1'b0, 1'b0, 8'h00);

        // Simultaneous ack and new rise on idx 3
        src[3] = 1'b1;
        tick(1);
        src[3] = 1'b0;
        tick(SX + 1);
        check_ip("sim_pre", 3, 1'b1);
        src[3] = 1'b1;
        tick(SX);
        do_ack(5'd3);
        check_ip("sim_ack_rise", 3, 1'b1);
        tick(1);
        push(1'b1, 5'd3, 8'h40, 1'b1);
        check_out("sim_irq_kept");

        // Edge-mode toggle while pending clears ip even with the line high
        cfg(3, 1'b1, 1'b0, 1'b1, 8'h40);
        check_ip("edge_toggle_clear", 3, 1'b0);
        src[3] = 1'b0;

        // Asynchronous reset mid-traffic
        cfg(30, 1'b1, 1'b0, 1'b0, 8'h33);
        src = 32'hFFFF_FFFF;
        tick(SX + 2);
        check_ipvec("pre_reset_ip", 32'hFFFF_FFFF);
        push(1'b1, 5'd9, 8'h80, 1'b1);
        check_out("pre_reset_winner");
        #2;
        rst = 1'b1;
        #1;
        push(1'b0, 5'd0, 8'h00, 1'b0);
        check_out("async_reset");
        check_ipvec("async_reset_ip", 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
